// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the Montgomery datapath: the domain converter, the
// Montgomery multiplier and the modular-exponentiation controller.
//   MONT_W       : default operand / modulus width in bits
//   MONT_K       : default number of modular doublings (R = 2^MONT_K)
//   mont_state_t : IDLE / RUN / DONE sequencing states
// ---------------------------------------------------------------------------
package mont_pkg;

   localparam int MONT_W = 256;
   localparam int MONT_K = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mont_state_t;

endpackage

// File: rtl/mod_double_step.sv
// ---------------------------------------------------------------------------
// mod_double_step
// One modular doubling: res = (2*t) mod nn, for t < nn.
// Purely combinational so it can later be retimed or widened to radix-4.
// Ports:
//   t   in  [W-1:0]  current residue (t < nn)
//   nn  in  [W-1:0]  modulus
//   res out [W-1:0]  2*t mod nn
// ---------------------------------------------------------------------------
module mod_double_step
   import mont_pkg::*;
#(
   parameter int W = MONT_W
) (
   input  logic [W-1:0] t,
   input  logic [W-1:0] nn,
   output logic [W-1:0] res
);

   logic [W:0] d;
   logic       ge;

   // Doubling is a left shift into a W+1-bit value; since t < nn < 2^W a
   // single conditional subtract brings it back below nn.
   always_comb begin
      d  = {t, 1'b0};
      ge = (d >= {1'b0, nn});
      if (ge) begin
         res = W'(d - {1'b0, nn});
      end else begin
         res = d[W-1:0];
      end
   end

endmodule

// File: rtl/mont_domain_converter.sv
// ---------------------------------------------------------------------------
// mont_domain_converter
// Converts an operand into Montgomery form: out = A * 2^K mod N, using one
// shift-and-conditional-subtract modular doubling per clock.
// Handshake: hold beg low to load A/N (and abort any run), raise and hold beg
// to run; out_ready rises after exactly K edges with beg high and stays up,
// with out stable, until beg falls.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   beg        in   level start (0 = idle/load, 1 = run/hold)
//   A          in   [W-1:0] operand, A < N
//   N          in   [W-1:0] modulus, N >= 1 (need not be odd)
//   out        out  [W-1:0] A*2^K mod N, valid while out_ready = 1
//   out_ready  out  done flag, (state == DONE) && beg
// Parameters: W operand width, K number of doublings (1..2W).
// ---------------------------------------------------------------------------
module mont_domain_converter
   import mont_pkg::*;
#(
   parameter int W = MONT_W,
   parameter int K = MONT_K
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         beg,
   input  logic [W-1:0] A,
   input  logic [W-1:0] N,
   output logic [W-1:0] out,
   output logic         out_ready
);

   localparam int             CW       = $clog2(K + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(K - 1);

   // The residue conceptually has a W+1-bit register, but its top bit only
   // ever feeds nothing (the next doubling uses t[W-1:0] and out is
   // t[W-1:0]), so only the low W bits are stored.
   logic [W-1:0]  t;
   logic [W-1:0]  t_next;
   logic [W-1:0]  t_dbl;
   logic [W-1:0]  nn;
   logic [W-1:0]  nn_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   mont_state_t   state;
   mont_state_t   state_next;

   mod_double_step #(
      .W (W)
   ) u_step (
      .t   (t),
      .nn  (nn),
      .res (t_dbl)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         t     <= {W{1'b0}};
         nn    <= {W{1'b0}};
         cnt   <= {CW{1'b0}};
      end else begin
         state <= state_next;
         t     <= t_next;
         nn    <= nn_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: beg low reloads from any state; beg high runs one
   // doubling per edge (the first one already on the IDLE edge) until K are
   // done, then holds.
   always_comb begin
      state_next = state;
      t_next     = t;
      nn_next    = nn;
      cnt_next   = cnt;
      if (!beg) begin
         state_next = IDLE;
         t_next     = A;
         nn_next    = N;
         cnt_next   = {CW{1'b0}};
      end else begin
         case (state)
            IDLE, RUN: begin
               t_next   = t_dbl;
               cnt_next = cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  state_next = DONE;
               end else begin
                  state_next = RUN;
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign out       = t;
   assign out_ready = (state == DONE) && beg;

endmodule

// File: tb/tb_mont_domain_converter.sv
// ---------------------------------------------------------------------------
// tb_mont_domain_converter
// Directed checks of the Montgomery domain converter at W=K=8, W=8/K=1,
// the default W=K=256, and W=K=64 against a 128-bit remainder model.
// ---------------------------------------------------------------------------
module tb_mont_domain_converter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // W=8, K=8
   logic       beg8;
   logic [7:0] a8, n8, out8;
   logic       rdy8;
   // W=8, K=1
   logic       beg1;
   logic [7:0] a1, n1, out1;
   logic       rdy1;
   // defaults W=256, K=256
   logic         beg256;
   logic [255:0] a256, n256, out256;
   logic         rdy256;
   // W=64, K=64
   logic        beg64;
   logic [63:0] a64, n64, out64;
   logic        rdy64;

   mont_domain_converter #(.W(8), .K(8)) u8 (
      .clk(clk), .reset(reset), .beg(beg8), .A(a8), .N(n8),
      .out(out8), .out_ready(rdy8)
   );

   mont_domain_converter #(.W(8), .K(1)) u1 (
      .clk(clk), .reset(reset), .beg(beg1), .A(a1), .N(n1),
      .out(out1), .out_ready(rdy1)
   );

   mont_domain_converter u256 (
      .clk(clk), .reset(reset), .beg(beg256), .A(a256), .N(n256),
      .out(out256), .out_ready(rdy256)
   );

   mont_domain_converter #(.W(64), .K(64)) u64 (
      .clk(clk), .reset(reset), .beg(beg64), .A(a64), .N(n64),
      .out(out64), .out_ready(rdy64)
   );

   task automatic check_eq(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---- W=8, K=8 helpers ----
   task automatic start8(input logic [7:0] a, input logic [7:0] n);
      @(posedge clk); #1;
      beg8 = 1'b0; a8 = a; n8 = n;
      @(posedge clk); #1;
      beg8 = 1'b1;
   endtask

   task automatic wait8(input string tag, input logic [7:0] exp,
                        input bit chk_out);
      repeat (7) @(posedge clk);
      #1;
      check_eq({tag, "_early"}, {255'd0, rdy8}, 256'd0);
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, {255'd0, rdy8}, 256'd1);
      if (chk_out) check_eq({tag, "_out"}, {248'd0, out8}, {248'd0, exp});
   endtask

   // ---- W=8, K=1 ----
   task automatic run1(input string tag, input logic [7:0] a,
                       input logic [7:0] n, input logic [7:0] exp);
      @(posedge clk); #1;
      beg1 = 1'b0; a1 = a; n1 = n;
      @(posedge clk); #1;
      beg1 = 1'b1;
      #1;
      check_eq({tag, "_early"}, {255'd0, rdy1}, 256'd0);
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, {255'd0, rdy1}, 256'd1);
      check_eq({tag, "_out"}, {248'd0, out1}, {248'd0, exp});
   endtask

   // ---- W=256, K=256 ----
   task automatic start256(input logic [255:0] a, input logic [255:0] n);
      @(posedge clk); #1;
      beg256 = 1'b0; a256 = a; n256 = n;
      @(posedge clk); #1;
      beg256 = 1'b1;
   endtask

   task automatic wait256(input string tag, input logic [255:0] exp);
      repeat (255) @(posedge clk);
      #1;
      check_eq({tag, "_early"}, {255'd0, rdy256}, 256'd0);
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, {255'd0, rdy256}, 256'd1);
      check_eq({tag, "_out"}, out256, exp);
   endtask

   // ---- W=64, K=64 ----
   task automatic run64(input string tag, input logic [63:0] a,
                        input logic [63:0] n, input logic [63:0] exp);
      @(posedge clk); #1;
      beg64 = 1'b0; a64 = a; n64 = n;
      @(posedge clk); #1;
      beg64 = 1'b1;
      repeat (63) @(posedge clk);
      #1;
      check_eq({tag, "_early"}, {255'd0, rdy64}, 256'd0);
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, {255'd0, rdy64}, 256'd1);
      check_eq({tag, "_out"}, {192'd0, out64}, {192'd0, exp});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] all_ones;
      logic [255:0] top_bit;
      logic [63:0]  rn, ra, rexp;
      logic [127:0] num, rem;

      all_ones = {256{1'b1}};
      top_bit  = {1'b1, 255'd0};

      reset  = 1'b1;
      beg8   = 1'b0; a8   = 8'd0;   n8   = 8'd1;
      beg1   = 1'b0; a1   = 8'd0;   n1   = 8'd1;
      beg256 = 1'b0; a256 = 256'd0; n256 = 256'd1;
      beg64  = 1'b0; a64  = 64'd0;  n64  = 64'd1;
      #12;
      check_eq("rst_out8",   {248'd0, out8},   256'd0);
      check_eq("rst_rdy8",   {255'd0, rdy8},   256'd0);
      check_eq("rst_out256", out256,           256'd0);
      check_eq("rst_rdy256", {255'd0, rdy256}, 256'd0);
      reset = 1'b0;

      // 3 * 2^8 mod 13 = 1, then hold while beg stays high
      start8(8'd3, 8'd13);
      wait8("a3n13", 8'd1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check_eq("hold_rdy", {255'd0, rdy8}, 256'd1);
      check_eq("hold_out", {248'd0, out8}, 256'd1);
      beg8 = 1'b0;
      #1;
      check_eq("drop_rdy", {255'd0, rdy8}, 256'd0);

      // 12*256 mod 13 = 4; A=0 -> 0; N=1 with A=0 -> 0
      start8(8'd12, 8'd13);
      wait8("a12n13", 8'd4, 1'b1);
      start8(8'd0, 8'd13);
      wait8("a0n13", 8'd0, 1'b1);
      start8(8'd0, 8'd1);
      wait8("a0n1", 8'd0, 1'b1);
      // A >= N: value unspecified, must still finish after K edges
      start8(8'd7, 8'd1);
      wait8("a7n1", 8'd0, 1'b0);

      // abort after 4 edges, reload A=5: 5*256 mod 13 = 6
      start8(8'd3, 8'd13);
      repeat (4) @(posedge clk);
      #1;
      beg8 = 1'b0; a8 = 8'd5;
      #1;
      check_eq("abort_rdy", {255'd0, rdy8}, 256'd0);
      @(posedge clk); #1;
      beg8 = 1'b1;
      wait8("abort", 8'd6, 1'b1);

      // K=1: single doubling
      run1("k1_a100", 8'd100, 8'd201, 8'd200);
      run1("k1_a150", 8'd150, 8'd201, 8'd99);

      // default width: 2^256 mod (2^256-1) = 1, 2^511 mod (2^256-1) = 2^255
      start256(256'd1, all_ones);
      wait256("d_a1", 256'd1);
      start256(top_bit, all_ones);
      wait256("d_a2p255", top_bit);

      // asynchronous reset in the middle of a default run
      start256(256'd1, all_ones);
      repeat (100) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_out", out256,           256'd0);
      check_eq("mid_rst_rdy", {255'd0, rdy256}, 256'd0);
      #2;
      reset  = 1'b0;
      beg256 = 1'b0;
      start256(256'd3, all_ones);
      wait256("post_rst", 256'd3);

      // W=K=64 directed: 2^64 mod (2^64-1) = 1; 2*2^64 mod 3 = 2
      run64("w64_a1", 64'd1, {64{1'b1}}, 64'd1);
      run64("w64_a2n3", 64'd2, 64'd3, 64'd2);

      // W=K=64 random vectors against A*2^64 mod N
      for (int v = 0; v < 1000; v++) begin
         rn = {$urandom, $urandom};
         if (v % 4 == 0) rn = 64'($urandom_range(1, 1000));
         if (rn == 64'd0) rn = 64'd1;
         ra   = {$urandom, $urandom} % rn;
         num  = {ra, 64'd0};
         rem  = num % {64'd0, rn};
         rexp = rem[63:0];
         run64($sformatf("rnd%0d", v), ra, rn, rexp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
